stir_heat_ctrl: RTL

STIR_HEAT_CTRL -- requirements
Module: stir_heat_ctrl

---
 rtl/stir_heat_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/stir_heat_ctrl.sv
// Stirrer motor soft-start ramp with PWM output, plus a hysteretic heater
// controller with over-temperature and stale-sensor protection.
module stir_heat_ctrl #(
   parameter int TICK_DIV    = 100000,
   parameter int PWM_PRESC   = 390,
   parameter int HYST        = 2,
   parameter int MIN_HOLD_MS = 500,
   parameter int TEMP_MAX    = 150,
   parameter int TIMEOUT_MS  = 2000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [7:0] temp_i,
   input  logic       tempValid_i,
   input  logic [3:0] tempMode_i,
   input  logic [3:0] velMode_i,
   output logic       motor_o,
   output logic       heater_o,
   output logic [1:0] fault_o,
   output logic [7:0] duty_o
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PRE_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PWM_PRESC - 1);
   localparam logic [15:0]      HOLD_LIM   = 16'(MIN_HOLD_MS);
   localparam logic [15:0]      TO_LIM     = 16'(TIMEOUT_MS);
   localparam logic [8:0]       TEMP_MAX_9 = 9'(TEMP_MAX);
   localparam logic signed [8:0] HYST_S    = 9'(HYST);

   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_OVER  = 2'b01;
   localparam logic [1:0] FLT_STALE = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HEAT  = 2'd1,
      COAST = 2'd2,
      FAULT = 2'd3
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // One step of the soft-start ramp: rise by one per tick, drop at once.
   function automatic logic [7:0] ramp_step(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic       tk);
      if (tgt < cur)
         return tgt;
      if (tk && (cur < tgt))
         return cur + 8'd1;
      return cur;
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [PRE_W-1:0] presc;
   logic [7:0]       pwm_cnt;
   logic [7:0]       duty_lat;
   logic [7:0]       duty_cur;
   logic [7:0]       target;
   logic             vel_ok;
   logic             sp_en;
   logic [7:0]       sp;
   logic signed [8:0] sp_lo;
   logic             temp_lo;
   logic             over_temp;
   logic             stale_hit;
   logic             hold_ok;
   logic             enter_hc;
   logic [15:0]      hold_cnt;
   logic [15:0]      stale_cnt;
   state_t           state;
   state_t           state_nx;
   logic [1:0]       fault_nx;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   // Motor target and ramp
   always_comb begin
      vel_ok = (velMode_i >= 4'd1) && (velMode_i <= 4'd9);
      target = 8'd0;
      if (en_i && vel_ok)
         target = 8'd28 * {4'd0, velMode_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         duty_cur <= 8'd0;
      else if (!en_i)
         duty_cur <= 8'd0;
      else
         duty_cur <= ramp_step(duty_cur, target, tick);
   end

   assign duty_o = duty_cur;

   // PWM: duty is sampled only at wrap so each period is glitch-free
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc    <= '0;
         pwm_cnt  <= 8'd0;
         duty_lat <= 8'd0;
         motor_o  <= 1'b0;
      end else begin
         motor_o <= (pwm_cnt < duty_lat);
         if (presc == PRE_LAST) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF)
               duty_lat <= duty_cur;
         end else begin
            presc <= presc + PRE_W'(1);
         end
      end
   end

   // Setpoint and thresholds; the low threshold is signed so small setpoints cannot wrap
   always_comb begin
      sp_en     = (tempMode_i >= 4'd1) && (tempMode_i <= 4'd9);
      sp        = 8'd20 + 8'd10 * {4'd0, tempMode_i};
      sp_lo     = $signed({1'b0, sp}) - HYST_S;
      temp_lo   = $signed({1'b0, temp_i}) <= sp_lo;
      over_temp = tempValid_i && ({1'b0, temp_i} >= TEMP_MAX_9);
      stale_hit = (stale_cnt >= TO_LIM);
      hold_ok   = (hold_cnt >= HOLD_LIM);
   end

   always_comb begin
      state_nx = state;
      fault_nx = fault_o;
      if (!en_i) begin
         state_nx = IDLE;
         fault_nx = FLT_NONE;
      end else if (state != FAULT) begin
         if (over_temp) begin
            state_nx = FAULT;
            fault_nx = FLT_OVER;
         end else if (((state == HEAT) || (state == COAST)) && stale_hit) begin
            state_nx = FAULT;
            fault_nx = FLT_STALE;
         end else if (!sp_en) begin
            state_nx = IDLE;
            fault_nx = FLT_NONE;
         end else if (tempValid_i) begin
            unique case (state)
               IDLE:    state_nx = (temp_i < sp) ? HEAT : COAST;
               HEAT:    if ((temp_i >= sp) && hold_ok) state_nx = COAST;
               COAST:   if (temp_lo && hold_ok) state_nx = HEAT;
               default: state_nx = state;
            endcase
         end
      end
   end

   assign enter_hc = (state_nx != state) && ((state_nx == HEAT) || (state_nx == COAST));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         heater_o <= 1'b0;
         fault_o  <= FLT_NONE;
      end else begin
         state    <= state_nx;
         heater_o <= (state_nx == HEAT);
         fault_o  <= fault_nx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_cnt  <= 16'd0;
         stale_cnt <= 16'd0;
      end else begin
         if (enter_hc)
            hold_cnt <= 16'd0;
         else if (tick)
            hold_cnt <= sat_inc(hold_cnt);
         if (!en_i || tempValid_i)
            stale_cnt <= 16'd0;
         else if (tick)
            stale_cnt <= sat_inc(stale_cnt);
      end
   end

endmodule
